// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions.
//   tx_state_t      - transmit FSM states
//   TICKS_PER_BIT   - 16x oversampling: baud enables per serial bit
//   TICK_LAST       - tick counter value on which a bit ends
//   LINE_IDLE / RDY_RST / DATA_RST - reset values shared with the receiver
//   parity_bit()    - final parity bit from the data XOR accumulator
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } tx_state_t;

  localparam int         TICKS_PER_BIT = 16;
  localparam logic [3:0] TICK_LAST     = 4'(TICKS_PER_BIT - 1);

  localparam logic       LINE_IDLE = 1'b1;
  localparam logic       RDY_RST   = 1'b1;
  localparam logic [7:0] DATA_RST  = 8'h00;

  // Odd parity inverts the even (plain XOR) result.
  function automatic logic parity_bit(input logic acc_s, input logic odd_n_even_s);
    return acc_s ^ odd_n_even_s;
  endfunction

endpackage

// File: rtl/coreuart_tx_async_if.sv
// coreuart_tx_async_if: bundle between the register file / TX FIFO and the
// transmit engine.
//   master: drives baud enable, frame config, write strobe/data, FIFO empty;
//           observes FIFO pop, TXRDY, TX_BUSY and the TX line.
//   slave : the transmit engine.
interface coreuart_tx_async_if;

  logic       BAUD_CLOCK;
  logic       BIT8;
  logic       PARITY_EN;
  logic       ODD_N_EVEN;
  logic       WEN;
  logic [7:0] TX_DATA;
  logic       FIFO_EMPTY;
  logic       READ_TX_FIFO;
  logic       TXRDY;
  logic       TX_BUSY;
  logic       TX;

  modport master (
    output BAUD_CLOCK, BIT8, PARITY_EN, ODD_N_EVEN, WEN, TX_DATA, FIFO_EMPTY,
    input  READ_TX_FIFO, TXRDY, TX_BUSY, TX
  );

  modport slave (
    input  BAUD_CLOCK, BIT8, PARITY_EN, ODD_N_EVEN, WEN, TX_DATA, FIFO_EMPTY,
    output READ_TX_FIFO, TXRDY, TX_BUSY, TX
  );

endinterface

// File: rtl/coreuart_tx_async.sv
// coreuart_tx_async: UART serial transmitter.
//   Frames a byte LSB-first: start bit, 7/8 data bits, optional parity, one
//   stop bit, each bit lasting 16 BAUD_CLOCK enables.
//   TX_FIFO=0: byte comes from an internal holding register loaded by WEN.
//   TX_FIFO=1: byte is popped from an external FIFO (READ_TX_FIFO strobe,
//              data captured one CLK later in LOAD).
// Ports:
//   CLK   - system clock
//   RESET - asynchronous active-high reset
//   bus   - slave side of coreuart_tx_async_if (all outputs registered)
module coreuart_tx_async
  import uart_pkg::*;
#(
  parameter logic TX_FIFO = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RESET,
  coreuart_tx_async_if.slave   bus
);

  tx_state_t  state_r;
  logic [3:0] tick_r;
  logic [2:0] bitcnt_r;
  logic [7:0] shift_r;
  logic [7:0] hold_r;
  logic       txrdy_r;
  logic       parity_r;
  logic       bit8_r;
  logic       par_en_r;
  logic       odd_r;
  logic       tx_r;
  logic       busy_r;
  logic       read_r;

  logic       pending_s;
  logic       wrap_s;
  logic [2:0] last_bit_s;

  // A byte is waiting: holding register full, or FIFO not empty.
  assign pending_s  = (TX_FIFO == 1'b0) ? ~txrdy_r : ~bus.FIFO_EMPTY;
  // Final tick of the current bit.
  assign wrap_s     = bus.BAUD_CLOCK & (tick_r == TICK_LAST);
  // Index of the last data bit for the frame being sent.
  assign last_bit_s = bit8_r ? 3'd7 : 3'd6;

  assign bus.TX           = tx_r;
  assign bus.TXRDY        = txrdy_r;
  assign bus.TX_BUSY      = busy_r;
  assign bus.READ_TX_FIFO = read_r;

  // Holding register, transmit FSM, bit timing and registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r  <= IDLE;
      tick_r   <= 4'd0;
      bitcnt_r <= 3'd0;
      shift_r  <= DATA_RST;
      hold_r   <= DATA_RST;
      txrdy_r  <= RDY_RST;
      parity_r <= 1'b0;
      bit8_r   <= 1'b0;
      par_en_r <= 1'b0;
      odd_r    <= 1'b0;
      tx_r     <= LINE_IDLE;
      busy_r   <= 1'b0;
      read_r   <= 1'b0;
    end else begin
      read_r <= 1'b0;

      // A write while the register is full is dropped. The write and the
      // IDLE transfer below are mutually exclusive (TXRDY 1 vs 0).
      if ((TX_FIFO == 1'b0) && bus.WEN && txrdy_r) begin
        hold_r  <= bus.TX_DATA;
        txrdy_r <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          tick_r   <= 4'd0;
          bitcnt_r <= 3'd0;
          parity_r <= 1'b0;
          tx_r     <= LINE_IDLE;
          if (bus.BAUD_CLOCK && pending_s) begin
            // Frame format is frozen here for the whole frame.
            bit8_r   <= bus.BIT8;
            par_en_r <= bus.PARITY_EN;
            odd_r    <= bus.ODD_N_EVEN;
            busy_r   <= 1'b1;
            if (TX_FIFO == 1'b0) begin
              shift_r <= hold_r;
              txrdy_r <= 1'b1;
              tx_r    <= 1'b0;
              state_r <= START;
            end else begin
              read_r  <= 1'b1;
              state_r <= LOAD;
            end
          end
        end
        LOAD: begin
          shift_r <= bus.TX_DATA;
          tx_r    <= 1'b0;
          state_r <= START;
        end
        START: begin
          if (bus.BAUD_CLOCK) begin
            tick_r <= tick_r + 4'd1;
          end
          if (wrap_s) begin
            tx_r    <= shift_r[0];
            state_r <= DATA;
          end
        end
        DATA: begin
          if (bus.BAUD_CLOCK) begin
            tick_r <= tick_r + 4'd1;
          end
          if (wrap_s) begin
            parity_r <= parity_r ^ shift_r[0];
            shift_r  <= {1'b0, shift_r[7:1]};
            bitcnt_r <= bitcnt_r + 3'd1;
            if (bitcnt_r == last_bit_s) begin
              if (par_en_r) begin
                // Include the bit just finished in the parity output.
                tx_r    <= parity_bit(parity_r ^ shift_r[0], odd_r);
                state_r <= PARITY;
              end else begin
                tx_r    <= 1'b1;
                state_r <= STOP;
              end
            end else begin
              tx_r <= shift_r[1];
            end
          end
        end
        PARITY: begin
          if (bus.BAUD_CLOCK) begin
            tick_r <= tick_r + 4'd1;
          end
          if (wrap_s) begin
            tx_r    <= 1'b1;
            state_r <= STOP;
          end
        end
        STOP: begin
          if (bus.BAUD_CLOCK) begin
            tick_r <= tick_r + 4'd1;
          end
          if (wrap_s) begin
            tx_r    <= LINE_IDLE;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          tx_r    <= LINE_IDLE;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coreuart_tx_async.sv
// tb_coreuart_tx_async: self-checking bench for coreuart_tx_async.
//   dut0 uses the holding register, dut1 an emulated external FIFO.
//   A frame-level model (whole frame built as a bit vector at frame start)
//   predicts TX, TXRDY, TX_BUSY and READ_TX_FIFO every cycle; directed
//   scenarios add literal expectations for frame contents and lengths.
module tb_coreuart_tx_async;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  coreuart_tx_async_if if0();
  coreuart_tx_async_if if1();

  coreuart_tx_async #(.TX_FIFO(1'b0)) dut0 (.CLK(clk), .RESET(rst), .bus(if0));
  coreuart_tx_async #(.TX_FIFO(1'b1)) dut1 (.CLK(clk), .RESET(rst), .bus(if1));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Baud enable: one pulse every baud_div CLKs (1 = held high).
  int   baud_div = 3;
  int   bcnt = 0;
  logic baud = 1'b0;
  always @(negedge clk) begin
    if (bcnt + 1 >= baud_div) bcnt <= 0;
    else bcnt <= bcnt + 1;
    baud <= (bcnt + 1 >= baud_div);
  end
  assign if0.BAUD_CLOCK = baud;
  assign if1.BAUD_CLOCK = baud;

  // External FIFO for dut1: head shown on TX_DATA, popped the CLK after a strobe.
  logic [7:0] fifo_mem [0:3];
  int   fifo_cnt = 0;
  int   fifo_rd = 0;
  int   rd_pulses = 0;
  logic rd_seen = 1'b0;
  assign if1.FIFO_EMPTY = (fifo_rd >= fifo_cnt);
  assign if1.TX_DATA    = fifo_mem[fifo_rd[1:0]];
  assign if1.WEN        = 1'b0;
  assign if1.BIT8       = 1'b1;
  assign if1.PARITY_EN  = 1'b1;
  assign if1.ODD_N_EVEN = 1'b0;
  always @(posedge clk) rd_seen <= if1.READ_TX_FIFO;
  always @(negedge clk) if (rd_seen) fifo_rd <= fifo_rd + 1;
  always @(negedge clk) if (if1.READ_TX_FIFO) rd_pulses <= rd_pulses + 1;

  // Baud ticks seen while dut0 is busy: frame length measurement.
  int tick_total = 0;
  always @(posedge clk) if (if0.TX_BUSY && if0.BAUD_CLOCK) tick_total <= tick_total + 1;

  // ---------------- frame-level model ----------------
  typedef struct packed {
    logic        tx;
    logic        txrdy;
    logic        busy;
    logic        rd;
    logic        active;
    logic        loading;
    logic        cb8;
    logic        cpe;
    logic        codd;
    logic [7:0]  hold;
    logic [11:0] frame;
    logic [3:0]  nbits;
    logic [3:0]  idx;
    logic [3:0]  tick;
  } model_t;

  function automatic model_t mreset();
    model_t m;
    m = '0;
    m.tx = 1'b1;
    m.txrdy = 1'b1;
    return m;
  endfunction

  // Whole frame as a bit list, bit 0 sent first; returns {nbits, frame}.
  function automatic logic [15:0] build(input logic [7:0] d, input logic b8,
                                        input logic pe, input logic odd);
    logic [11:0] f;
    int n;
    int k;
    f = '1;
    f[0] = 1'b0;
    n = b8 ? 8 : 7;
    for (int i = 0; i < n; i++) f[1 + i] = d[i];
    k = 1 + n;
    if (pe) begin
      f[k] = (^(d & (b8 ? 8'hFF : 8'h7F))) ^ odd;
      k++;
    end
    k++;
    return {4'(k), f};
  endfunction

  function automatic model_t step(input model_t m, input logic fifo_mode,
                                  input logic bd, input logic b8, input logic pe,
                                  input logic odd, input logic wen,
                                  input logic [7:0] d, input logic empty);
    model_t n;
    n = m;
    n.rd = 1'b0;
    if (!fifo_mode && wen && m.txrdy) begin
      n.txrdy = 1'b0;
      n.hold  = d;
    end
    if (m.active) begin
      if (bd) begin
        if (m.tick == 4'd15) begin
          n.tick = 4'd0;
          n.idx  = m.idx + 4'd1;
          if (4'(m.idx + 4'd1) == m.nbits) begin
            n.active = 1'b0;
            n.busy   = 1'b0;
            n.tx     = 1'b1;
          end else begin
            n.tx = m.frame[m.idx + 4'd1];
          end
        end else begin
          n.tick = m.tick + 4'd1;
        end
      end
    end else if (m.loading) begin
      {n.nbits, n.frame} = build(d, m.cb8, m.cpe, m.codd);
      n.loading = 1'b0;
      n.active  = 1'b1;
      n.idx     = 4'd0;
      n.tick    = 4'd0;
      n.tx      = 1'b0;
    end else if (bd) begin
      if (!fifo_mode && !m.txrdy) begin
        {n.nbits, n.frame} = build(m.hold, b8, pe, odd);
        n.active = 1'b1;
        n.idx    = 4'd0;
        n.tick   = 4'd0;
        n.tx     = 1'b0;
        n.busy   = 1'b1;
        n.txrdy  = 1'b1;
      end else if (fifo_mode && !empty) begin
        n.rd      = 1'b1;
        n.loading = 1'b1;
        n.busy    = 1'b1;
        n.cb8     = b8;
        n.cpe     = pe;
        n.codd    = odd;
      end
    end
    return n;
  endfunction

  model_t m0;
  model_t m1;
  always @(posedge clk or posedge rst) begin
    if (rst) m0 <= mreset();
    else m0 <= step(m0, 1'b0, if0.BAUD_CLOCK, if0.BIT8, if0.PARITY_EN, if0.ODD_N_EVEN,
                    if0.WEN, if0.TX_DATA, if0.FIFO_EMPTY);
  end
  always @(posedge clk or posedge rst) begin
    if (rst) m1 <= mreset();
    else m1 <= step(m1, 1'b1, if1.BAUD_CLOCK, if1.BIT8, if1.PARITY_EN, if1.ODD_N_EVEN,
                    if1.WEN, if1.TX_DATA, if1.FIFO_EMPTY);
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("tx0",    32'(if0.TX),           32'(m0.tx));
    chk("txrdy0", 32'(if0.TXRDY),        32'(m0.txrdy));
    chk("busy0",  32'(if0.TX_BUSY),      32'(m0.busy));
    chk("rd0",    32'(if0.READ_TX_FIFO), 32'(m0.rd));
    chk("tx1",    32'(if1.TX),           32'(m1.tx));
    chk("txrdy1", 32'(if1.TXRDY),        32'(m1.txrdy));
    chk("busy1",  32'(if1.TX_BUSY),      32'(m1.busy));
    chk("rd1",    32'(if1.READ_TX_FIFO), 32'(m1.rd));
  end

  // ---------------- directed stimulus ----------------
  task automatic wr(input logic [7:0] d);
    @(negedge clk);
    if0.WEN = 1'b1;
    if0.TX_DATA = d;
    @(negedge clk);
    if0.WEN = 1'b0;
  endtask

  task automatic wait_active(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (m0.active) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({name, "_start_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_busy_low(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (!if0.TX_BUSY) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({name, "_end_timeout"}, 32'd0, 32'd1);
  endtask

  int t0;

  // Write a byte, wait for its start bit and pin the model's frame.
  task automatic start_frame(input logic [7:0] d, input string name,
                             input logic [11:0] exp_frame, input logic [3:0] exp_n);
    wr(d);
    chk({name, "_txrdy_wr"}, 32'(if0.TXRDY), 32'd0);
    wait_active(name);
    t0 = tick_total;
    chk({name, "_txrdy_start"}, 32'(if0.TXRDY), 32'd1);
    chk({name, "_startbit"}, 32'(if0.TX), 32'd0);
    chk({name, "_frame"}, 32'(m0.frame), 32'(exp_frame));
    chk({name, "_nbits"}, 32'(m0.nbits), 32'(exp_n));
  endtask

  task automatic end_frame(input string name, input int exp_ticks);
    wait_busy_low(name);
    chk({name, "_ticks"}, tick_total - t0, exp_ticks);
  endtask

  task automatic cfg(input logic b8, input logic pe, input logic odd);
    if0.BIT8 = b8;
    if0.PARITY_EN = pe;
    if0.ODD_N_EVEN = odd;
  endtask

  initial begin
    fifo_mem[0] = 8'h11;
    fifo_mem[1] = 8'h22;
    fifo_mem[2] = 8'h33;
    fifo_mem[3] = 8'h00;
    fifo_cnt = 3;
    if0.WEN = 1'b0;
    if0.TX_DATA = 8'h00;
    if0.FIFO_EMPTY = 1'b1;
    cfg(1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx",    32'(if0.TX),           32'd1);
    chk("rst_txrdy", 32'(if0.TXRDY),        32'd1);
    chk("rst_busy",  32'(if0.TX_BUSY),      32'd0);
    chk("rst_rd",    32'(if1.READ_TX_FIFO), 32'd0);
    rst = 1'b0;

    // 8N1, 0x55, baud every 3 CLKs
    start_frame(8'h55, "f55", {2'b11, 1'b1, 8'h55, 1'b0}, 4'd10);
    end_frame("f55", 160);
    // 8O1 0x03 -> parity 1; 8E1 0x07 -> 1; 8E1 0x03 -> 0
    cfg(1'b1, 1'b1, 1'b1);
    start_frame(8'h03, "o03", {1'b1, 1'b1, 1'b1, 8'h03, 1'b0}, 4'd11);
    end_frame("o03", 176);
    cfg(1'b1, 1'b1, 1'b0);
    start_frame(8'h07, "e07", {1'b1, 1'b1, 1'b1, 8'h07, 1'b0}, 4'd11);
    end_frame("e07", 176);
    start_frame(8'h03, "e03", {1'b1, 1'b1, 1'b0, 8'h03, 1'b0}, 4'd11);
    end_frame("e03", 176);
    // 7N1 0xFF: seven ones, 144 ticks
    cfg(1'b0, 1'b0, 1'b0);
    start_frame(8'hFF, "s7ff", {3'b111, 1'b1, 7'h7F, 1'b0}, 4'd9);
    end_frame("s7ff", 144);
    // 7E1: 0xFF parity 1, 0x80 parity 0 (bit 7 not counted)
    cfg(1'b0, 1'b1, 1'b0);
    start_frame(8'hFF, "e7ff", {2'b11, 1'b1, 1'b1, 7'h7F, 1'b0}, 4'd10);
    end_frame("e7ff", 160);
    start_frame(8'h80, "e780", {2'b11, 1'b1, 1'b0, 7'h00, 1'b0}, 4'd10);
    cfg(1'b1, 1'b0, 1'b1);  // mid-frame change must not alter this frame
    end_frame("e780", 160);

    // Back-to-back with BAUD_CLOCK held high
    baud_div = 1;
    cfg(1'b1, 1'b0, 1'b0);
    start_frame(8'hA5, "bbA5", {2'b11, 1'b1, 8'hA5, 1'b0}, 4'd10);
    wr(8'h3C);
    chk("bb_rdy_wr2", 32'(if0.TXRDY), 32'd0);
    wr(8'hFF);
    chk("bb_rdy_wr3", 32'(if0.TXRDY), 32'd0);
    wait_busy_low("bbA5");
    if0.WEN = 1'b1;
    if0.TX_DATA = 8'h99;    // coincides with the holding->shift transfer
    @(negedge clk);
    if0.WEN = 1'b0;
    chk("bb_gap_busy",  32'(if0.TX_BUSY), 32'd1);
    chk("bb_gap_start", 32'(if0.TX),      32'd0);
    chk("bb_collide_rdy", 32'(if0.TXRDY), 32'd1);
    chk("bb3C_frame", 32'(m0.frame), 32'({2'b11, 1'b1, 8'h3C, 1'b0}));
    wait_busy_low("bb3C");
    repeat (40) @(negedge clk);
    chk("bb_dropped_busy", 32'(if0.TX_BUSY), 32'd0);
    chk("bb_dropped_rdy",  32'(if0.TXRDY),   32'd1);

    // FIFO instance: three pops, three frames, idle afterwards
    for (int i = 0; i < 5000; i++) begin
      if (fifo_rd == 3 && !if1.TX_BUSY) break;
      @(negedge clk);
    end
    chk("fifo_pops",   32'(rd_pulses),    32'd3);
    chk("fifo_rdptr",  32'(fifo_rd),      32'd3);
    chk("fifo_busy",   32'(if1.TX_BUSY),  32'd0);
    chk("fifo_txrdy",  32'(if1.TXRDY),    32'd1);

    // Asynchronous reset during data bit 3 of 0xB4 (bit 3 = 0)
    start_frame(8'hB4, "rB4", {2'b11, 1'b1, 8'hB4, 1'b0}, 4'd10);
    repeat (72) @(negedge clk);
    chk("r_bit3", 32'(if0.TX), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("r_async_tx",    32'(if0.TX),      32'd1);
    chk("r_async_txrdy", 32'(if0.TXRDY),   32'd1);
    chk("r_async_busy",  32'(if0.TX_BUSY), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("r_idle_tx",   32'(if0.TX),      32'd1);
    chk("r_idle_busy", 32'(if0.TX_BUSY), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
